// File: rtl/program_loader.sv
// Program loader: packs instruction fields into 11-bit words, writes them to the
// instruction RAM from address 0 upward, reads each one back to verify it, and holds
// the CPU in reset until a load has completed successfully.
module program_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [3:0]        in_op1,
    input  logic [3:0]        in_op2,
    input  logic              in_last,
    output logic              ram_csn,
    output logic              ram_rwn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [10:0]       ram_wdata,
    input  logic [10:0]       ram_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   load_count,
    output logic              err_illegal,
    output logic              err_verify,
    output logic              trunc,
    output logic              cpu_reset_n
);

    typedef enum logic [2:0] {
        StIdle, StAccept, StWrite, StRead, StCheck, StDone, StError
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [10:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              err_ill_q, err_ill_d;
    logic              err_ver_q, err_ver_d;
    logic              trunc_q, trunc_d;

    // State and datapath registers; reset forces the idle, CPU-held-in-reset picture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            count_q   <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            err_ill_q <= 1'b0;
            err_ver_q <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            word_q    <= word_d;
            last_q    <= last_d;
            err_ill_q <= err_ill_d;
            err_ver_q <= err_ver_d;
            trunc_q   <= trunc_d;
        end
    end

    // Next-state and datapath update: accept, write, read back, compare, repeat.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        word_d    = word_q;
        last_d    = last_q;
        err_ill_d = err_ill_q;
        err_ver_d = err_ver_q;
        trunc_d   = trunc_q;
        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d   = StAccept;
                    addr_d    = '0;
                    count_d   = '0;
                    err_ill_d = 1'b0;
                    err_ver_d = 1'b0;
                    trunc_d   = 1'b0;
                end
            end
            StAccept: begin
                if (in_valid) begin
                    if (in_opcode == 3'b111) begin
                        err_ill_d = 1'b1;
                        state_d   = StError;
                    end else begin
                        word_d  = {in_opcode, in_op1, in_op2};
                        last_d  = in_last;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: state_d = StRead;
            StRead:  state_d = StCheck;
            StCheck: begin
                if (ram_rdata != word_q) begin
                    err_ver_d = 1'b1;
                    state_d   = StError;
                end else begin
                    if (count_q != FullCount) count_d = count_q + 1'b1;
                    if (last_q) begin
                        state_d = StDone;
                    end else if (addr_q == LastAddr) begin
                        // RAM is full but the program has not ended: stop without wrapping.
                        trunc_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StAccept;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore output decode from the registered state and datapath.
    always_comb begin
        in_ready    = (state_q == StAccept);
        busy        = (state_q == StAccept) || (state_q == StWrite) ||
                      (state_q == StRead)   || (state_q == StCheck);
        ram_csn     = !((state_q == StWrite) || (state_q == StRead));
        ram_rwn     = (state_q != StWrite);
        ram_addr    = addr_q;
        ram_wdata   = word_q;
        done        = (state_q == StDone);
        cpu_reset_n = (state_q == StDone);
        load_count  = count_q;
        err_illegal = err_ill_q;
        err_verify  = err_ver_q;
        trunc       = trunc_q;
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a behavioural 16x11 RAM and strobe monitors.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_n, start, in_valid, in_ready, in_last;
    logic [2:0]  in_opcode;
    logic [3:0]  in_op1, in_op2;
    logic        ram_csn, ram_rwn;
    logic [3:0]  ram_addr;
    logic [10:0] ram_wdata, ram_rdata;
    logic        busy, done, err_illegal, err_verify, trunc, cpu_reset_n;
    logic [4:0]  load_count;

    logic [10:0] mem [16];
    logic        flip1 = 1'b0;
    int          cyc = 0, hs_cnt = 0, wr_cnt = 0, rd_cnt = 0, a2_cnt = 0;
    int          checks = 0, errors = 0;

    program_loader #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2),
        .in_last(in_last), .ram_csn(ram_csn), .ram_rwn(ram_rwn), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .done(done),
        .load_count(load_count), .err_illegal(err_illegal), .err_verify(err_verify),
        .trunc(trunc), .cpu_reset_n(cpu_reset_n)
    );

    always #5 clk = ~clk;

    // RAM model (registered read data, optional bit-0 flip on address 1) and monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
        if (!ram_csn && !ram_rwn) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (!ram_csn && ram_rwn) begin
            ram_rdata <= mem[ram_addr] ^ ((flip1 && ram_addr == 4'd1) ? 11'd1 : 11'd0);
            rd_cnt <= rd_cnt + 1;
        end
        if (!ram_csn && ram_addr == 4'd2) a2_cnt <= a2_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word after 'gap' idle cycles of junk fields; returns the handshake cycle.
    task automatic load_word(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                             input logic last, input int gap, output int hs_cyc);
        int n = 0;
        hs_cyc = -1;
        for (int g = 0; g < gap; g++) begin
            in_valid  = 1'b0;
            in_opcode = 3'($urandom_range(0, 7));
            in_op1    = 4'($urandom_range(0, 15));
            in_op2    = 4'($urandom_range(0, 15));
            in_last   = 1'($urandom_range(0, 1));
            tick();
        end
        in_opcode = op; in_op1 = a; in_op2 = b; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) chk("handshake_timeout", 32'd0, 32'd1);
        else begin
            tick();
            hs_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int c);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        c = cyc;
    endtask

    initial begin
        int h0, h, dc, hs_b, wr_b, rd_b, a2_b;
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = 3'd0; in_op1 = 4'd0; in_op2 = 4'd0;
        #3;
        // {csn, rwn, in_ready, busy, done, err_illegal, err_verify, trunc, cpu_reset_n}
        chk("reset_ctrl", {ram_csn, ram_rwn, in_ready, busy, done, err_illegal, err_verify,
                           trunc, cpu_reset_n}, 9'b110000000);
        chk("reset_addr_wdata", {ram_addr, ram_wdata}, 15'd0);
        chk("reset_count", load_count, 5'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Basic three-word program with in_valid held.
        hs_b = hs_cnt; wr_b = wr_cnt; rd_b = rd_cnt;
        do_start();
        chk("start_ready_busy", {in_ready, busy}, 2'b11);
        load_word(3'b001, 4'd2, 4'd5, 1'b0, 0, h0);
        load_word(3'b010, 4'd2, 4'd1, 1'b0, 0, h);
        load_word(3'b110, 4'd2, 4'd0, 1'b1, 0, h);
        wait_done(dc);
        // Done appears in the 12th cycle after the first handshake edge: 11 edges later.
        chk("done_latency", 32'(dc - h0), 32'd11);
        chk("basic_ram", {mem[0], mem[1], mem[2]}, {11'h125, 11'h221, 11'h620});
        chk("basic_count", load_count, 5'd3);
        chk("basic_flags", {done, cpu_reset_n, err_illegal, err_verify, trunc}, 5'b11000);
        chk("basic_strobes", {8'(hs_cnt - hs_b), 8'(wr_cnt - wr_b), 8'(rd_cnt - rd_b)},
            {8'd3, 8'd3, 8'd3});

        // 16 words, no in_last: fills RAM, truncates; a 17th word is never accepted.
        wr_b = wr_cnt;
        do_start();
        for (int i = 0; i < 16; i++)
            load_word(3'(i % 7), 4'(i), 4'(15 - i), 1'b0, 0, h);
        wait_done(dc);
        chk("trunc_flags", {done, trunc, cpu_reset_n, err_illegal, err_verify}, 5'b11100);
        chk("trunc_count", load_count, 5'd16);
        chk("trunc_writes", 32'(wr_cnt - wr_b), 32'd16);
        chk("trunc_mem15", {mem[0], mem[15]}, {11'h00F, 11'h1F0});
        hs_b = hs_cnt;
        in_opcode = 3'b001; in_op1 = 4'd1; in_op2 = 4'd1; in_last = 1'b1; in_valid = 1'b1;
        tick(); tick(); tick();
        chk("word17_ready", in_ready, 1'b0);
        chk("word17_no_hs", 32'(hs_cnt - hs_b), 32'd0);
        in_valid = 1'b0;

        // in_last on word 16 ends normally without trunc.
        do_start();
        for (int i = 0; i < 16; i++)
            load_word(3'b011, 4'(i), 4'd3, i == 15, 0, h);
        wait_done(dc);
        chk("full_last", {done, trunc, load_count}, {1'b1, 1'b0, 5'd16});

        // Same three-word program with random in_valid gaps and junk fields in between.
        hs_b = hs_cnt; wr_b = wr_cnt; rd_b = rd_cnt;
        do_start();
        load_word(3'b001, 4'd2, 4'd5, 1'b0, $urandom_range(1, 4), h);
        load_word(3'b010, 4'd2, 4'd1, 1'b0, $urandom_range(1, 4), h);
        load_word(3'b110, 4'd2, 4'd0, 1'b1, $urandom_range(1, 4), h);
        wait_done(dc);
        chk("gap_ram", {mem[0], mem[1], mem[2]}, {11'h125, 11'h221, 11'h620});
        chk("gap_strobes", {8'(hs_cnt - hs_b), 8'(wr_cnt - wr_b), 8'(rd_cnt - rd_b)},
            {8'd3, 8'd3, 8'd3});
        chk("gap_count", load_count, 5'd3);

        // Illegal opcode on the second word.
        wr_b = wr_cnt;
        do_start();
        load_word(3'b101, 4'd7, 4'd7, 1'b0, 0, h);
        load_word(3'b111, 4'd1, 4'd1, 1'b0, 0, h);
        tick();
        chk("illegal_flags", {err_illegal, cpu_reset_n, done, busy}, 4'b1000);
        chk("illegal_count", load_count, 5'd1);
        chk("illegal_writes", {32'(wr_cnt - wr_b), 21'd0, mem[0]}, {32'd1, 32'h577});
        do_start();
        chk("illegal_cleared", {err_illegal, in_ready}, 2'b01);

        // Readback of address 1 corrupted: verify error, nothing touches address 2.
        flip1 = 1'b1;
        a2_b = a2_cnt;
        load_word(3'b001, 4'd1, 4'd1, 1'b0, 0, h);
        load_word(3'b010, 4'd2, 4'd2, 1'b0, 0, h);
        tick(); tick(); tick(); tick(); tick();
        chk("verify_flags", {err_verify, err_illegal, cpu_reset_n, done, in_ready}, 5'b10000);
        chk("verify_count", load_count, 5'd1);
        chk("verify_no_addr2", 32'(a2_cnt - a2_b), 32'd0);
        flip1 = 1'b0;

        // Reset during the write of word 2.
        do_start();
        load_word(3'b001, 4'd1, 4'd2, 1'b0, 0, h);
        load_word(3'b010, 4'd3, 4'd4, 1'b0, 0, h);
        chk("pre_reset_write", {ram_csn, ram_rwn}, 2'b00);
        reset_n = 1'b0;
        #1;
        wr_b = wr_cnt;
        chk("midreset_ctrl", {ram_csn, ram_rwn, in_ready, busy, done, err_illegal, err_verify,
                              trunc, cpu_reset_n}, 9'b110000000);
        chk("midreset_data", {ram_addr, ram_wdata, load_count}, 20'd0);
        tick(); tick();
        chk("midreset_no_strobe", 32'(wr_cnt - wr_b), 32'd0);
        reset_n = 1'b1;
        tick();
        do_start();
        load_word(3'b011, 4'd4, 4'd5, 1'b0, 0, h);
        load_word(3'b100, 4'd5, 4'd6, 1'b1, 0, h);
        wait_done(dc);
        chk("reload_ram", {mem[0], mem[1]}, {11'h345, 11'h456});
        chk("reload_state", {done, cpu_reset_n, load_count}, {2'b11, 5'd2});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_from_done", {cpu_reset_n, done, in_ready, busy}, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
